// File: rtl/fpu_accum.sv
// Streaming IEEE-754 frame accumulator closing the fpu_add feedback loop.
// Optional feature macro: FPU_ACCUM_OVF_EN (clamp to max finite + sticky overflow flag).
// Ports (fpu_accum):
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand stream handshake, in_data operand, in_last frame end
//   out_valid/out_ready sum stream handshake
//   out_data            frame sum, out_count operands in frame (saturating)
//   out_ovf             sum overflowed (0 unless FPU_ACCUM_OVF_EN)
// Ports (fpu_add): a_i, b_i operands, sum_o truncated combinational sum.

module fpu_add #(
   parameter bit double = 1'b0
) (
   input  logic [(double ? 64 : 32)-1:0] a_i,
   input  logic [(double ? 64 : 32)-1:0] b_i,
   output logic [(double ? 64 : 32)-1:0] sum_o
);
   localparam int SIZE = double ? 64 : 32;
   localparam int EXP  = double ? 11 : 8;
   localparam int MANT = double ? 52 : 23;
   localparam int EMAX = (1 << EXP) - 1;

   logic            sa, sb, sbig;
   logic [EXP-1:0]  ea, eb, ebig, esml, diff;
   logic [MANT:0]   ma, mb, mbig, msml, msh;
   logic [MANT+1:0] sumv, norm;
   logic [MANT-1:0] rfrac;
   int              p, shift, rexp;

   always_comb begin
      sa    = a_i[SIZE-1];
      sb    = b_i[SIZE-1];
      ea    = a_i[SIZE-2:MANT];
      eb    = b_i[SIZE-2:MANT];
      // exponent 0 is flushed to zero (no subnormal support)
      ma    = (ea == '0) ? '0 : {1'b1, a_i[MANT-1:0]};
      mb    = (eb == '0) ? '0 : {1'b1, b_i[MANT-1:0]};
      if ({eb, mb} > {ea, ma}) begin
         sbig = sb; ebig = eb; mbig = mb; esml = ea; msml = ma;
      end else begin
         sbig = sa; ebig = ea; mbig = ma; esml = eb; msml = mb;
      end
      diff  = ebig - esml;
      msh   = msml >> diff;
      if (sa == sb)
         sumv = {1'b0, mbig} + {1'b0, msh};
      else
         sumv = {1'b0, mbig} - {1'b0, msh};
      p = 0;
      for (int i = 0; i <= MANT + 1; i++)
         if (sumv[i]) p = i;
      shift = MANT - p;
      norm  = '0;
      rfrac = '0;
      rexp  = 0;
      sum_o = '0;
      if (sumv != '0) begin
         if (sumv[MANT+1]) begin
            rexp  = int'(ebig) + 1;
            rfrac = sumv[MANT:1];
         end else begin
            rexp  = int'(ebig) - shift;
            norm  = sumv << shift;
            rfrac = norm[MANT-1:0];
         end
         if (rexp >= EMAX)
            sum_o = {sbig, {EXP{1'b1}}, {MANT{1'b0}}};
         else if (rexp > 0)
            sum_o = {sbig, EXP'(rexp), rfrac};
      end
   end
endmodule

module fpu_accum #(
   parameter bit double = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [(double ? 64 : 32)-1:0] in_data,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [(double ? 64 : 32)-1:0] out_data,
   output logic [15:0]                   out_count,
   output logic                          out_ovf
);
   localparam int SIZE = double ? 64 : 32;
   localparam int MANT = double ? 52 : 23;
   localparam int EXP  = double ? 11 : 8;

   typedef enum logic [1:0] {
      S_FIRST,
      S_ACCUM,
      S_HOLD
   } state_t;

   state_t            state_q;
   logic [SIZE-1:0]   acc_q, acc_d, sum;
   logic [15:0]       cnt_q, cnt_d;
   logic              in_ready_q, out_valid_q;
   logic [SIZE-1:0]   out_data_q;
   logic [15:0]       out_count_q;
   logic              ovf_d;

   fpu_add #(.double(double)) u_add (
      .a_i   (acc_q),
      .b_i   (in_data),
      .sum_o (sum)
   );

   assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef FPU_ACCUM_OVF_EN
   logic sum_ovf;
   logic ovf_q, out_ovf_q;
   always_comb begin
      sum_ovf = &sum[SIZE-2:MANT];
      // saturate to the largest finite magnitude, keeping the sign
      acc_d   = sum_ovf ?
                {sum[SIZE-1], {(EXP-1){1'b1}}, 1'b0, {MANT{1'b1}}} : sum;
      ovf_d   = ovf_q | sum_ovf;
   end
   assign out_ovf = out_ovf_q;
`else
   always_comb begin
      acc_d = sum;
      ovf_d = 1'b0;
   end
   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FIRST;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
`ifdef FPU_ACCUM_OVF_EN
         ovf_q       <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_FIRST: if (in_valid) begin
               // first operand bypasses the adder
               acc_q <= in_data;
               cnt_q <= 16'd1;
               if (in_last) begin
                  state_q     <= S_HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= in_data;
                  out_count_q <= 16'd1;
`ifdef FPU_ACCUM_OVF_EN
                  out_ovf_q   <= 1'b0;
`endif
               end else begin
                  state_q <= S_ACCUM;
               end
            end
            S_ACCUM: if (in_valid) begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
`ifdef FPU_ACCUM_OVF_EN
               ovf_q <= ovf_d;
`endif
               if (in_last) begin
                  state_q     <= S_HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_d;
                  out_count_q <= cnt_d;
`ifdef FPU_ACCUM_OVF_EN
                  out_ovf_q   <= ovf_d;
`endif
               end
            end
            S_HOLD: if (out_ready) begin
               state_q     <= S_FIRST;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
`ifdef FPU_ACCUM_OVF_EN
               ovf_q       <= 1'b0;
`endif
            end
            default: state_q <= S_FIRST;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

   // keeps ovf_d referenced in the build without the overflow feature
   logic unused_ovf;
   assign unused_ovf = ovf_d;
endmodule

// File: tb/tb_fpu_accum.sv
// Directed self-checking bench for fpu_accum (single precision).
// Expected values are hand-computed IEEE-754 constants.

module tb_fpu_accum;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_data;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [15:0] out_count;
   logic        out_ovf;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fpu_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive one operand at negedge, wait for in_ready, accept at posedge
   task automatic send(input logic [31:0] d, input logic l);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("send_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] d,
                             input logic [15:0] c, input logic o);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(d));
      check({tag, "_count"}, 64'(out_count), 64'(c));
      check({tag, "_ovf"}, 64'(out_ovf), 64'(o));
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_out_ovf", 64'(out_ovf), 64'd0);

      // 1 + 2 + 3 = 6, result visible the cycle after the last accept
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b0);
      send(32'h40400000, 1'b1);
      @(negedge clk);
      check("f1_valid", 64'(out_valid), 64'd1);
      check("f1_data", 64'(out_data), 64'h40C00000);
      check("f1_count", 64'(out_count), 64'd3);
      check("f1_in_ready", 64'(in_ready), 64'd0);

      // single operand bypasses the adder
      send(32'hC1200000, 1'b1);
      expect_out("single", 32'hC1200000, 16'd1, 1'b0);

      // cancellation to +0
      send(32'h40000000, 1'b0);
      send(32'hC0000000, 1'b1);
      expect_out("cancel", 32'h00000000, 16'd2, 1'b0);

      // gap inside a frame with an unqualified in_last: 1.0 + 0.5
      send(32'h3F800000, 1'b0);
      @(negedge clk);
      in_last = 1'b1;
      repeat (3) @(negedge clk);
      in_last = 1'b0;
      send(32'h3F000000, 1'b1);
      expect_out("gap", 32'h3FC00000, 16'd2, 1'b0);

      // backpressure in HOLD with a pending operand
      @(negedge clk);
      out_ready = 1'b0;
      send(32'h3F800000, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_data", 64'(out_data), 64'h3F800000);
         check("bp_count", 64'(out_count), 64'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("rel_valid", 64'(out_valid), 64'd0);
      check("rel_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      check("next_valid", 64'(out_valid), 64'd1);
      check("next_data", 64'(out_data), 64'h40000000);
      check("next_count", 64'(out_count), 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;

      // exponent overflow
      send(32'h7F000000, 1'b0);
      send(32'h7F000000, 1'b1);
`ifdef FPU_ACCUM_OVF_EN
      expect_out("ovf", 32'h7F7FFFFF, 16'd2, 1'b1);
`else
      expect_out("ovf", 32'h7F800000, 16'd2, 1'b0);
`endif

      // reset mid-frame discards the partial sum
      send(32'h40000000, 1'b0);
      send(32'h40400000, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_count", 64'(out_count), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      send(32'h3F800000, 1'b1);
      expect_out("post_rst", 32'h3F800000, 16'd1, 1'b0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
